// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode constants and immediate format codes shared by the immediate generator
package imm_gen_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_B = 3'd1,
    FMT_J = 3'd2,
    FMT_U = 3'd3
  } imm_fmt_e;
endpackage

// File: rtl/imm_generator_if.sv
// imm_generator_if: request/result bundle; master drives in_valid/opcode/imm_input/imm_input_uj, slave returns imm_output/out_valid/imm_fmt
interface imm_generator_if;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [11:0] imm_input;
  logic [19:0] imm_input_uj;
  logic [31:0] imm_output;
  logic        out_valid;
  logic [2:0]  imm_fmt;
  modport master (output in_valid, opcode, imm_input, imm_input_uj, input imm_output, out_valid, imm_fmt);
  modport slave  (input in_valid, opcode, imm_input, imm_input_uj, output imm_output, out_valid, imm_fmt);
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode -> imm_fmt decode; AUIPC decodes as U-type when IMM_GEN_AUIPC_EN is defined
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_fmt_e   fmt
);
  logic is_u;
`ifdef IMM_GEN_AUIPC_EN
  assign is_u = (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
`else
  assign is_u = (opcode == OPC_LUI);
`endif
  always_comb begin
    fmt = (opcode == OPC_BRANCH) ? FMT_B :
          (opcode == OPC_JAL)    ? FMT_J :
          is_u                   ? FMT_U : FMT_I;
  end
endmodule

// File: rtl/imm_generator.sv
// imm_generator: one-cycle registered RISC-V immediate generator (clk, async active-low rst_n, imm_generator_if.slave bus); optional IMM_GEN_AUIPC_EN
module imm_generator
  import imm_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  imm_generator_if.slave  bus
);
  imm_fmt_e    fmt;
  logic [31:0] imm_next;
  imm_decode u_decode (
    .opcode (bus.opcode),
    .fmt    (fmt)
  );
  always_comb begin
    imm_next = (fmt == FMT_B) ? {{19{bus.imm_input[11]}}, bus.imm_input, 1'b0} :
               (fmt == FMT_J) ? {{11{bus.imm_input_uj[19]}}, bus.imm_input_uj, 1'b0} :
               (fmt == FMT_U) ? {bus.imm_input_uj, 12'b0} :
                                {{20{bus.imm_input[11]}}, bus.imm_input};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imm_output <= '0;
      bus.imm_fmt    <= FMT_I;
      bus.out_valid  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.imm_output <= imm_next;
        bus.imm_fmt    <= fmt;
      end
    end
  end
endmodule

// File: tb/tb_imm_generator.sv
// tb_imm_generator: directed and randomized checks of imm_generator against a behavioural immediate model
module tb_imm_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_out = '0;
  logic [2:0]  exp_fmt = '0;
`ifdef IMM_GEN_AUIPC_EN
  localparam bit AUIPC_U = 1'b1;
`else
  localparam bit AUIPC_U = 1'b0;
`endif

  imm_generator_if bus ();
  imm_generator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [6:0] op);
    if (op == 7'b1100011) return 3'd1;
    if (op == 7'b1101111) return 3'd2;
    if (op == 7'b0110111) return 3'd3;
    if (op == 7'b0010111 && AUIPC_U) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [6:0] op, input logic [11:0] i, input logic [19:0] u);
    longint si = (i >= 12'd2048) ? longint'(i) - 4096 : longint'(i);
    longint su = (u >= 20'd524288) ? longint'(u) - 1048576 : longint'(u);
    case (ref_fmt(op))
      3'd1:    return 32'(si * 2);
      3'd2:    return 32'(su * 2);
      3'd3:    return 32'(longint'(u) * 4096);
      default: return 32'(si);
    endcase
  endfunction

  task automatic step(input logic v, input logic [6:0] op, input logic [11:0] i, input logic [19:0] u);
    @(negedge clk);
    bus.in_valid = v;
    bus.opcode = op;
    bus.imm_input = i;
    bus.imm_input_uj = u;
    @(posedge clk);
    #1;
    if (v) begin
      exp_out = ref_imm(op, i, u);
      exp_fmt = ref_fmt(op);
    end
    check("out_valid", 32'(bus.out_valid), 32'(v));
    check("imm_output", bus.imm_output, exp_out);
    check("imm_fmt", 32'(bus.imm_fmt), 32'(exp_fmt));
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [11:0] i;
    logic [19:0] u;
    logic [31:0] exp;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.in_valid = 1'b1;
    bus.opcode = 7'b1100011;
    bus.imm_input = 12'h024;
    bus.imm_input_uj = 20'hABCDE;
    #2;
    check("reset_out", bus.imm_output, 32'h0);
    check("reset_fmt", 32'(bus.imm_fmt), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("reset_drop_out", bus.imm_output, 32'h0);
    check("reset_drop_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    vecs.push_back('{7'b1100011, 12'h024, 20'h55555, 32'h00000048, 3'd1});
    vecs.push_back('{7'b1100011, 12'h800, 20'h00000, 32'hFFFFF000, 3'd1});
    vecs.push_back('{7'b1101111, 12'h7FF, 20'h80000, 32'hFFF00000, 3'd2});
    vecs.push_back('{7'b1100011, 12'hFFF, 20'h00000, 32'hFFFFFFFE, 3'd1});
    vecs.push_back('{7'b1101111, 12'h000, 20'hFFFFF, 32'hFFFFFFFE, 3'd2});
    vecs.push_back('{7'b0110111, 12'hFFF, 20'hABCDE, 32'hABCDE000, 3'd3});
    vecs.push_back('{7'b1101111, 12'h800, 20'h00002, 32'h00000004, 3'd2});
    vecs.push_back('{7'b0010011, 12'h00F, 20'hFFFFF, 32'h0000000F, 3'd0});
    vecs.push_back('{7'b0100011, 12'hFFF, 20'h00000, 32'hFFFFFFFF, 3'd0});
    vecs.push_back('{7'b0000000, 12'h000, 20'h00000, 32'h00000000, 3'd0});
    vecs.push_back('{7'b0010111, 12'h800, 20'h12345, AUIPC_U ? 32'h12345000 : 32'hFFFFF800, AUIPC_U ? 3'd3 : 3'd0});
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].op, vecs[k].i, vecs[k].u);
      check($sformatf("vec%0d_out", k), bus.imm_output, vecs[k].exp);
      check($sformatf("vec%0d_fmt", k), 32'(bus.imm_fmt), 32'(vecs[k].fmt));
    end

    step(1'b1, 7'b0110111, 12'h000, 20'h13579);
    step(1'b0, 7'b1100011, 12'hFFF, 20'hFFFFF);
    check("hold_out", bus.imm_output, 32'h13579000);
    step(1'b0, 7'b0000000, 12'h123, 20'h45678);

    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = 7'b1100011;
        1: op = 7'b1101111;
        2: op = 7'b0110111;
        3: op = 7'b0010111;
        default: op = 7'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), op, 12'($urandom), 20'($urandom));
      if (n == 200) begin
        step(1'b1, 7'b0110111, 12'h000, 20'hFEDCB);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", bus.imm_output, 32'h0);
        check("async_rst_fmt", 32'(bus.imm_fmt), 32'h0);
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_edge_drop", bus.imm_output, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        exp_out = '0;
        exp_fmt = '0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_generator.md
IMM_GENERATOR -- requirements
Module: imm_generator

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  qualifies opcode/imm_input/imm_input_uj this cycle.
REQ-005 opcode  input  7  RISC-V major opcode.
REQ-006 imm_input  input  12  raw 12-bit immediate field (I/S/B formats).
REQ-007 imm_input_uj  input  20  raw 20-bit immediate field (U/J formats).
REQ-008 imm_output  output  32  generated, sign-extended/shifted immediate, registered.
REQ-009 out_valid  output  1  high for exactly one cycle when imm_output holds a new result.
REQ-010 imm_fmt  output  3  registered format code of the last accepted opcode.

Function
REQ-011 Latency SHALL be one cycle: inputs sampled at rising clk with in_valid=1 appear on imm_output/imm_fmt/out_valid after that edge.
REQ-012 With in_valid=0 at an edge, imm_output and imm_fmt SHALL hold their values and out_valid SHALL be 0.
REQ-013 opcode 7'b1100011 (B) SHALL yield sign-extend(imm_input, 32) shifted left 1, LSB 0, upper bit discarded.
REQ-014 opcode 7'b1101111 (J) SHALL yield sign-extend(imm_input_uj, 32) shifted left 1, LSB 0, upper bit discarded.
REQ-015 opcode 7'b0110111 (U/LUI) SHALL yield {imm_input_uj, 12'b0}.
REQ-016 Every other opcode (I, S, loads, JALR, undefined) SHALL yield sign-extend(imm_input, 32) unshifted.
REQ-017 Sign extension SHALL replicate bit 11 of imm_input or bit 19 of imm_input_uj; the unused input field SHALL not influence the result.
REQ-018 imm_fmt codes: 0=I/default, 1=B, 2=J, 3=U; 4..7 reserved, never driven.
REQ-019 No X-propagation: every 7-bit opcode value SHALL decode to exactly one format.

Reset
REQ-020 While rst_n=0: imm_output=32'h0, imm_fmt=0, out_valid=0, asserted immediately regardless of clk.
REQ-021 Reset deassertion SHALL take effect at the next rising clk; a transaction whose in_valid edge coincides with active reset SHALL be dropped.

Configuration
REQ-022 Macro IMM_GEN_AUIPC_EN: when defined, opcode 7'b0010111 (AUIPC) SHALL decode as U-type (imm_fmt=3, {imm_input_uj,12'b0}); when undefined, it SHALL follow the default I-type rule.

Structure
REQ-023 Package imm_gen_pkg SHALL hold the opcode constants (OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC) and the imm_fmt enumeration typedef.
REQ-024 Sub-module imm_decode SHALL be purely combinational (opcode -> imm_fmt); imm_generator instantiates it and holds the datapath mux and output registers.

Verification
REQ-025 B: opcode 1100011, imm_input 12'h024 -> imm_output 32'h00000048, imm_fmt 1, out_valid one cycle later.
REQ-026 B/J negative: imm_input 12'h800 (B) -> 32'hFFFFF000; imm_input_uj 20'h80000 (J) -> 32'hFFF00000; all-ones 12'hFFF (B) or 20'hFFFFF (J) -> 32'hFFFFFFFE.
REQ-027 U: opcode 0110111, imm_input_uj 20'hABCDE -> 32'hABCDE000; J 20'h00002 -> 32'h00000004.
REQ-028 Default: opcode 0010011 imm_input 12'h00F -> 32'h0000000F; opcode 0100011 imm_input 12'hFFF -> 32'hFFFFFFFF; all-zero inputs, opcode 0 -> 32'h0.
REQ-029 Hold/reset: in_valid=0 keeps prior imm_output with out_valid=0; rst_n pulled low mid-stream clears outputs asynchronously before the next clk edge.
REQ-030 Macro: opcode 0010111, imm_input_uj 20'h12345, imm_input 12'h800 -> 32'h12345000 with IMM_GEN_AUIPC_EN, 32'hFFFFF800 without.
